mem_lsu: RTL and testbench
==========================

# mem_lsu

Data-side load/store unit for the MEM stage of the pipelined core. It takes the memory operation latched in the EX/MEM register and drives the core's data sram-like master port (`data_req` … `data_data_ok`). It aligns store data and sign- or zero-extends load data. It holds the pipeline through `stall` until the bus transaction completes, then presents the result to MEM/WB for exactly one cycle.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset (low = reset)
- `valid_i`  in  1  EX/MEM holds a live instruction
- `mem_op_i`  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9–15 are treated as none
- `addr_i`  in  32  effective byte address
- `wdata_i`  in  32  store source register value
- `data_req`  out  1  sram-like request
- `data_wr`  out  1  1 = write
- `data_size`  out  2  0 byte, 1 half, 2 word
- `data_addr`  out  32  byte address, equal to `addr_i` unmodified
- `data_wdata`  out  32  replicated store data
- `data_rdata`  in  32  read data, valid with `data_data_ok`
- `data_addr_ok`  in  1  request accepted
- `data_data_ok`  in  1  read data returned / write completed
- `stall`  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- `load_data_o`  out  32  extended load result, valid in DONE
- `done_o`  out  1  operation complete this cycle
- `addr_err_o`  out  1  misaligned access; no bus request is issued

## Operation
- Memory op (`is_mem`): `valid_i` high and `mem_op_i` in the range 1–8.
- Misalignment (`addr_err_o`, combinational):
  - asserted when `is_mem` and either: LH/LHU/SH with `addr_i[0]=1`, or LW/SW with `addr_i[1:0]≠0`;
  - while asserted, `data_req=0`, `stall=0`, and the FSM stays in IDLE.
- FSM has three states:
  - IDLE: `data_req = is_mem & !addr_err_o`. If `data_req & data_addr_ok`, go to WAIT and latch op and `addr_i[1:0]`. Otherwise stay, holding `data_req` high and all request fields stable.
  - WAIT: `data_req=0`. `data_data_ok` is ignored in every other state. On `data_data_ok`, latch `data_rdata` into the result register and go to DONE.
  - DONE: `done_o=1`, `stall=0`, `load_data_o` valid. Unconditionally return to IDLE next cycle; the pipeline advances on this edge.
- `stall = is_mem & !addr_err_o & (state≠DONE)`.
- Request field encoding:
  - `data_wr` = op is SB, SH or SW.
  - `data_size`: byte ops → 0, half ops → 1, word ops → 2.
- Store data: SB → `{4{wdata_i[7:0]}}`; SH → `{2{wdata_i[15:0]}}`; SW → `wdata_i`.
- Load extraction, using the latched `addr[1:0]` (little-endian):
  - LB/LBU: select byte `addr[1:0]`, sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select half `addr[1]`, sign-extend (LH) or zero-extend (LHU).
  - LW: full word.
  - For stores, `load_data_o` is 0.
- Request outputs are 0 whenever `data_req=0`.
- Reset (`rst` low, asynchronous):
  - state goes to IDLE and the result register to 0;
  - `data_req`, `stall`, `done_o` and `addr_err_o` are driven by IDLE-state logic, so they are 0 when no op is presented;
  - an in-flight transaction is abandoned, since the bus is reset together with the core.

## Timing
- Best case (`addr_ok` in cycle 0, `data_ok` in cycle 1):
  - `stall` is high in cycles 0–1;
  - DONE occurs in cycle 2, with `done_o=1` and `stall=0`;
  - MEM/WB captures the result at the end of cycle 2.
- Each cycle of `addr_ok` delay adds one stall cycle in IDLE. Each cycle of `data_ok` delay adds one stall cycle in WAIT.
- `addr_ok` and `data_ok` never arrive in the same cycle for one request. A `data_ok` seen in IDLE is ignored.
- Non-memory instruction or misaligned access: zero added latency and no stall.
- Back-to-back memory ops: after DONE the next op re-enters IDLE and asserts `data_req` in the cycle following DONE. There is at most one outstanding transaction.

## Test plan
- LW at 0x100, `addr_ok` in cycle 0, `data_rdata=0x89ABCDEF` with `data_ok` in cycle 1 → `data_req` high only in cycle 0 with `data_size=2`; `stall` high in cycles 0–1; `done_o=1` and `load_data_o=0x89ABCDEF` in cycle 2.
- LB and LBU at address 0x103 with `rdata=0x80112233` → LB yields 0xFFFFFF80; LBU yields 0x00000080.
- SH at 0x102 with `wdata_i=0x1234ABCD`, `addr_ok` delayed 3 cycles → `data_req` held high for 4 cycles with `data_wr=1`, `data_size=1` and `data_wdata=0xABCDABCD` stable throughout; `stall` releases only in DONE.
- LW at 0x101 → `addr_err_o=1`, `data_req=0`, `stall=0`.
- Two back-to-back loads, the second arriving while the first sits in DONE → exactly two requests issued, each result presented for exactly one DONE cycle.
- Pull `rst` low while in WAIT → state returns to IDLE immediately; `stall` and `done_o` go to 0; a later stray `data_ok` in IDLE is ignored.

Source files
------------

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : MEM-stage load/store unit driving an sram-like data master port.
// Revision : 1.0
// ============================================================================
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        stall,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        addr_err_o
);

    localparam logic [3:0] c_op_lb  = 4'd1;
    localparam logic [3:0] c_op_lbu = 4'd2;
    localparam logic [3:0] c_op_lh  = 4'd3;
    localparam logic [3:0] c_op_lhu = 4'd4;
    localparam logic [3:0] c_op_lw  = 4'd5;
    localparam logic [3:0] c_op_sb  = 4'd6;
    localparam logic [3:0] c_op_sh  = 4'd7;
    localparam logic [3:0] c_op_sw  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_lo;
    logic [31:0] r_result;

    logic        w_is_mem;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_req_ok;
    logic        w_req;
    logic [1:0]  w_size;
    logic [31:0] w_store_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // Decode of the op currently held in EX/MEM.
    always_comb begin
        w_is_mem   = valid_i && (mem_op_i >= c_op_lb) && (mem_op_i <= c_op_sw);
        w_is_half  = (mem_op_i == c_op_lh) || (mem_op_i == c_op_lhu) || (mem_op_i == c_op_sh);
        w_is_word  = (mem_op_i == c_op_lw) || (mem_op_i == c_op_sw);
        w_is_store = (mem_op_i == c_op_sb) || (mem_op_i == c_op_sh) || (mem_op_i == c_op_sw);
        w_misalign = (w_is_half && addr_i[0]) || (w_is_word && (addr_i[1:0] != 2'b00));
        w_req_ok   = w_is_mem && !w_misalign;
        w_size     = w_is_word ? 2'd2 : (w_is_half ? 2'd1 : 2'd0);
        if (mem_op_i == c_op_sb)
            w_store_data = {4{wdata_i[7:0]}};
        else if (mem_op_i == c_op_sh)
            w_store_data = {2{wdata_i[15:0]}};
        else
            w_store_data = wdata_i;
    end

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        done_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = w_req_ok;
                if (w_req && data_addr_ok)
                    w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_data_ok)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Little-endian extraction using the offset captured at request acceptance.
    always_comb begin
        case (r_lo)
            2'd0:    w_byte = data_rdata[7:0];
            2'd1:    w_byte = data_rdata[15:8];
            2'd2:    w_byte = data_rdata[23:16];
            default: w_byte = data_rdata[31:24];
        endcase
        w_half = r_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (r_op)
            c_op_lb:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_ext = {24'd0, w_byte};
            c_op_lh:  w_ext = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_ext = {16'd0, w_half};
            c_op_lw:  w_ext = data_rdata;
            default:  w_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 4'd0;
            r_lo     <= 2'd0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_req && data_addr_ok) begin
                r_op <= mem_op_i;
                r_lo <= addr_i[1:0];
            end
            if (r_state == ST_WAIT && data_data_ok)
                r_result <= w_ext;
        end
    end

    assign data_req    = w_req;
    assign data_wr     = w_req && w_is_store;
    assign data_size   = w_req ? w_size : 2'd0;
    assign data_addr   = w_req ? addr_i : 32'd0;
    assign data_wdata  = (w_req && w_is_store) ? w_store_data : 32'd0;
    assign stall       = w_req_ok && (r_state != ST_DONE);
    assign addr_err_o  = w_is_mem && w_misalign;
    assign load_data_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Directed vector bench for mem_lsu with multi-cycle bus sequences.
// Revision : 1.0
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        stall;
    logic [31:0] load_data_o;
    logic        done_o;
    logic        addr_err_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_done = 0;

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .stall        (stall),
        .load_data_o  (load_data_o),
        .done_o       (done_o),
        .addr_err_o   (addr_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (data_req && data_addr_ok) n_acc <= n_acc + 1;
        if (done_o) n_done <= n_done + 1;
    end

    typedef struct {
        string       name;
        logic        valid;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_err;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i      = 1'b0;
        mem_op_i     = 4'd0;
        addr_i       = 32'd0;
        wdata_i      = 32'd0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
    endtask

    // Best-case bus: addr_ok in cycle 0, data_ok in cycle 1, DONE in cycle 2.
    task automatic run_vec(input vec_t v);
        valid_i      = v.valid;
        mem_op_i     = v.op;
        addr_i       = v.addr;
        wdata_i      = v.wdata;
        data_addr_ok = v.exp_req;
        data_data_ok = 1'b0;
        @(negedge clk);
        chk({v.name, " err"},   {31'd0, addr_err_o}, {31'd0, v.exp_err});
        chk({v.name, " req0"},  {31'd0, data_req},   {31'd0, v.exp_req});
        chk({v.name, " stall0"},{31'd0, stall},      {31'd0, v.exp_req});
        if (v.exp_req) begin
            chk({v.name, " wr"},   {31'd0, data_wr},   {31'd0, v.exp_wr});
            chk({v.name, " size"}, {30'd0, data_size}, {30'd0, v.exp_size});
            chk({v.name, " addr"}, data_addr, v.addr);
            if (v.exp_wr) chk({v.name, " wdata"}, data_wdata, v.exp_wdata);
            next_cycle();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b1;
            data_rdata   = v.rdata;
            @(negedge clk);
            chk({v.name, " req1"},   {31'd0, data_req}, 32'd0);
            chk({v.name, " stall1"}, {31'd0, stall},    32'd1);
            chk({v.name, " done1"},  {31'd0, done_o},   32'd0);
            next_cycle();
            data_data_ok = 1'b0;
            data_rdata   = 32'h5A5A5A5A;
            @(negedge clk);
            chk({v.name, " done2"},  {31'd0, done_o}, 32'd1);
            chk({v.name, " stall2"}, {31'd0, stall},  32'd0);
            chk({v.name, " load"},   load_data_o, v.exp_load);
        end else begin
            next_cycle();
            @(negedge clk);
            chk({v.name, " nodone"}, {31'd0, done_o}, 32'd0);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        int base_acc;
        int base_done;
        rst = 1'b0;
        idle_inputs();

        vecs[0]  = '{"LW100",   1'b1, 4'd5, 32'h100, 32'h0,        32'h89ABCDEF, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0,        32'h89ABCDEF};
        vecs[1]  = '{"LB103",   1'b1, 4'd1, 32'h103, 32'h0,        32'h80112233, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{"LBU103",  1'b1, 4'd2, 32'h103, 32'h0,        32'h80112233, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        32'h00000080};
        vecs[3]  = '{"LH102",   1'b1, 4'd3, 32'h102, 32'h0,        32'h80112233, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0,        32'hFFFF8011};
        vecs[4]  = '{"LHU100",  1'b1, 4'd4, 32'h100, 32'h0,        32'h80119233, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0,        32'h00009233};
        vecs[5]  = '{"LB101",   1'b1, 4'd1, 32'h101, 32'h0,        32'h80112233, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        32'h00000022};
        vecs[6]  = '{"SB102",   1'b1, 4'd6, 32'h102, 32'h000000A5, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 32'hA5A5A5A5, 32'h0};
        vecs[7]  = '{"SW104",   1'b1, 4'd8, 32'h104, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 32'h0};
        vecs[8]  = '{"LW101",   1'b1, 4'd5, 32'h101, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
        vecs[9]  = '{"SH103",   1'b1, 4'd7, 32'h103, 32'h1234,     32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
        vecs[10] = '{"LH101",   1'b1, 4'd3, 32'h101, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
        vecs[11] = '{"SW102",   1'b1, 4'd8, 32'h102, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
        vecs[12] = '{"OP9",     1'b1, 4'd9, 32'h101, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0};
        vecs[13] = '{"NOVALID", 1'b0, 4'd5, 32'h101, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req",   {31'd0, data_req},   32'd0);
        chk("rst stall", {31'd0, stall},      32'd0);
        chk("rst done",  {31'd0, done_o},     32'd0);
        chk("rst err",   {31'd0, addr_err_o}, 32'd0);
        chk("rst load",  load_data_o,         32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // SH with addr_ok delayed three cycles: request must stay stable.
        valid_i  = 1'b1;
        mem_op_i = 4'd7;
        addr_i   = 32'h102;
        wdata_i  = 32'h1234ABCD;
        for (int c = 0; c < 4; c++) begin
            data_addr_ok = (c == 3);
            @(negedge clk);
            chk("SHd req",   {31'd0, data_req},  32'd1);
            chk("SHd wr",    {31'd0, data_wr},   32'd1);
            chk("SHd size",  {30'd0, data_size}, 32'd1);
            chk("SHd wdata", data_wdata,         32'hABCDABCD);
            chk("SHd stall", {31'd0, stall},     32'd1);
            next_cycle();
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        @(negedge clk);
        chk("SHd wait req",   {31'd0, data_req}, 32'd0);
        chk("SHd wait stall", {31'd0, stall},    32'd1);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("SHd done",  {31'd0, done_o}, 32'd1);
        chk("SHd stall", {31'd0, stall},  32'd0);
        chk("SHd load",  load_data_o,     32'd0);
        next_cycle();
        idle_inputs();
        next_cycle();

        // Back-to-back loads: second op appears right after the first DONE.
        base_acc  = n_acc;
        base_done = n_done;
        valid_i      = 1'b1;
        mem_op_i     = 4'd5;
        addr_i       = 32'h200;
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h11111111;
        next_cycle();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        @(negedge clk);
        chk("B2B done1", {31'd0, done_o}, 32'd1);
        chk("B2B load1", load_data_o,     32'h11111111);
        next_cycle();
        mem_op_i     = 4'd4;
        addr_i       = 32'h202;
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("B2B req2",  {31'd0, data_req},  32'd1);
        chk("B2B done0", {31'd0, done_o},    32'd0);
        chk("B2B addr2", data_addr,          32'h202);
        next_cycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hBEEF0000;
        next_cycle();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        @(negedge clk);
        chk("B2B done2", {31'd0, done_o}, 32'd1);
        chk("B2B load2", load_data_o,     32'h0000BEEF);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("B2B after", {31'd0, done_o}, 32'd0);
        next_cycle();
        chk("B2B reqs",  n_acc - base_acc,   32'd2);
        chk("B2B dones", n_done - base_done, 32'd2);

        // Reset while in WAIT, then a stray data_ok in IDLE.
        valid_i      = 1'b1;
        mem_op_i     = 4'd5;
        addr_i       = 32'h300;
        data_addr_ok = 1'b1;
        next_cycle();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("RW stall", {31'd0, stall}, 32'd1);
        #2;
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("RW stall0", {31'd0, stall},    32'd0);
        chk("RW done0",  {31'd0, done_o},   32'd0);
        chk("RW req0",   {31'd0, data_req}, 32'd0);
        next_cycle();
        rst          = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFEF00D;
        @(negedge clk);
        chk("RW stray done", {31'd0, done_o}, 32'd0);
        next_cycle();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("RW stray done2", {31'd0, done_o}, 32'd0);
        chk("RW load",        load_data_o,     32'd0);
        next_cycle();
        valid_i  = 1'b1;
        mem_op_i = 4'd5;
        addr_i   = 32'h304;
        @(negedge clk);
        chk("RW idle req", {31'd0, data_req}, 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
